// File: rtl/temp_telemetry_pkg.sv
// Shared constants, FSM state type and frame byte helper for the temperature
// telemetry reporter.
package temp_telemetry_pkg;

  localparam logic [7:0]  SOF        = 8'hA5;
  localparam int unsigned FRAME_LEN  = 6;
  localparam int unsigned FLG_ALARM  = 0;
  localparam int unsigned FLG_FORCED = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    NEXT
  } state_t;

  // Byte idx of a channel frame; the last byte is the mod-256 sum of the others.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  ch,
    input logic [15:0] t,
    input logic [7:0]  flags
  );
    logic [7:0] sum;
    sum = SOF + ch + t[15:8] + t[7:0] + flags;
    case (idx)
      3'd0:    frame_byte = SOF;
      3'd1:    frame_byte = ch;
      3'd2:    frame_byte = t[15:8];
      3'd3:    frame_byte = t[7:0];
      3'd4:    frame_byte = flags;
      default: frame_byte = sum;
    endcase
  endfunction

endpackage

// File: rtl/temp_telemetry_alarm.sv
// Per-channel over-temperature alarm with hysteresis on a signed DS18B20
// reading; registered every cycle.
module temp_alarm_hyst #(
  parameter logic [15:0] ALARM_HI = 16'h01E0,
  parameter logic [15:0] HYST     = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] t,
  output logic        alarm
);

  // 17-bit signed levels so the clear threshold cannot wrap.
  localparam logic signed [16:0] SET_LVL = $signed({ALARM_HI[15], ALARM_HI});
  localparam logic signed [16:0] CLR_LVL = SET_LVL - $signed({HYST[15], HYST});

  logic signed [16:0] t_ext;

  always_comb t_ext = $signed({t[15], t});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (t_ext >= SET_LVL) begin
      alarm <= 1'b1;
    end else if (t_ext < CLR_LVL) begin
      alarm <= 1'b0;
    end
  end

endmodule

// File: rtl/temp_telemetry.sv
// Periodic / forced multi-channel temperature reporter: snapshots all channels
// and streams one checksummed 6-byte frame per channel over valid/ready.
module temp_telemetry
  import temp_telemetry_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned PERIOD_MS = 1000,
  parameter int unsigned NUM_CH    = 1,
  parameter logic [15:0] ALARM_HI  = 16'h01E0,
  parameter logic [15:0] HYST      = 16'h0020
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [16*NUM_CH-1:0]  t_data,
  input  logic                  force_send,
  input  logic                  tx_rdy,
  output logic [7:0]            tx_data,
  output logic                  tx_vld,
  output logic                  busy,
  output logic [NUM_CH-1:0]     alarm,
  output logic                  alarm_any
);

  localparam int unsigned PERIOD_CYC = CLK_HZ / 1000 * PERIOD_MS;
  localparam int unsigned CW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic                   tick, trig, start, xfer, last_ch;
  logic                   pending, pend_forced, forced;
  logic [1:0]             ch;
  logic [2:0]             bidx;
  logic [16*NUM_CH-1:0]   snap;
  logic [NUM_CH-1:0]      snap_alarm;
  logic [15:0]            cur_t;
  logic                   cur_alarm;
  logic [7:0]             flags;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_alarm
    temp_alarm_hyst #(
      .ALARM_HI (ALARM_HI),
      .HYST     (HYST)
    ) u_alarm (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_data[16*k +: 16]),
      .alarm (alarm[k])
    );
  end

  always_comb alarm_any = |alarm;

  always_comb begin
    tick    = (cnt == CW'(PERIOD_CYC - 1));
    trig    = tick | force_send | pending;
    busy    = (state != IDLE);
    tx_vld  = (state == SEND);
    xfer    = tx_vld & tx_rdy;
    last_ch = (ch == 2'(NUM_CH - 1));
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = LOAD;
          start     = 1'b1;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (xfer && bidx == 3'(FRAME_LEN - 1)) state_nxt = NEXT;
      end
      NEXT: begin
        if (!last_ch) begin
          state_nxt = SEND;
        end else if (pending) begin
          state_nxt = LOAD;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_t     = '0;
    cur_alarm = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch == 2'(k)) begin
        cur_t     = snap[16*k +: 16];
        cur_alarm = snap_alarm[k];
      end
    end
  end

  always_comb begin
    flags             = '0;
    flags[FLG_ALARM]  = cur_alarm;
    flags[FLG_FORCED] = forced;
  end

  always_comb tx_data = tx_vld ? frame_byte(bidx, {6'b0, ch}, cur_t, flags) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pending     <= 1'b0;
      pend_forced <= 1'b0;
      forced      <= 1'b0;
      ch          <= '0;
      bidx        <= '0;
      snap        <= '0;
      snap_alarm  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= tick ? '0 : cnt + 1'b1;

      // A starting report consumes every trigger present in its start cycle.
      if (start) begin
        pending     <= 1'b0;
        pend_forced <= 1'b0;
        forced      <= force_send | pend_forced;
      end else begin
        if (busy && (tick || force_send)) pending     <= 1'b1;
        if (busy && force_send)           pend_forced <= 1'b1;
        if (state_nxt == IDLE)            forced      <= 1'b0;
      end

      case (state)
        LOAD: begin
          snap       <= t_data;
          snap_alarm <= alarm;
          ch         <= '0;
          bidx       <= '0;
        end
        SEND: begin
          if (xfer && bidx != 3'(FRAME_LEN - 1)) bidx <= bidx + 1'b1;
        end
        NEXT: begin
          if (!last_ch) begin
            ch   <= ch + 1'b1;
            bidx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_telemetry.sv
// Self-checking bench for temp_telemetry: slot-queue reference model checked
// every cycle, plus directed frames with hand-computed bytes.
module tb_temp_telemetry;

  localparam int unsigned NCH  = 2;
  localparam int unsigned PCYC = 100;
  localparam int K_LOAD = 0;
  localparam int K_BYTE = 1;
  localparam int K_NEXT = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] t_data;
  logic        force_send;
  logic        tx_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        busy;
  logic [1:0]  alarm;
  logic        alarm_any;

  int total = 0;
  int bad   = 0;
  int busy_cnt = 0;

  temp_telemetry #(
    .CLK_HZ    (1000),
    .PERIOD_MS (100),
    .NUM_CH    (NCH),
    .ALARM_HI  (16'h01E0),
    .HYST      (16'h0020)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .t_data     (t_data),
    .force_send (force_send),
    .tx_rdy     (tx_rdy),
    .tx_data    (tx_data),
    .tx_vld     (tx_vld),
    .busy       (busy),
    .alarm      (alarm),
    .alarm_any  (alarm_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         kind;
    logic [7:0] d;
    bit         last;
  } slot_t;

  slot_t slots[$];
  int    m_cnt    = 0;
  bit    m_pend   = 0;
  bit    m_pforce = 0;
  bit    m_forced = 0;
  bit    m_alarm[NCH];

  function automatic void push_frame(int c, logic [15:0] tv, bit al, bit fo);
    int b[6];
    slot_t s;
    b[0] = 165;
    b[1] = c;
    b[2] = int'(tv[15:8]);
    b[3] = int'(tv[7:0]);
    b[4] = (fo ? 2 : 0) + (al ? 1 : 0);
    b[5] = (b[0] + b[1] + b[2] + b[3] + b[4]) % 256;
    for (int i = 0; i < 6; i++) begin
      s.kind = K_BYTE; s.d = 8'(b[i]); s.last = 0;
      slots.push_back(s);
    end
    s.kind = K_NEXT; s.d = 8'h00; s.last = (c == NCH - 1);
    slots.push_back(s);
  endfunction

  always @(posedge clk) begin
    bit    tk, was_busy, st;
    slot_t s;
    if (!rst_n) begin
      slots.delete();
      m_cnt = 0; m_pend = 0; m_pforce = 0; m_forced = 0;
      for (int k = 0; k < NCH; k++) m_alarm[k] = 0;
    end else begin
      tk       = (m_cnt == PCYC - 1);
      was_busy = (slots.size() != 0);
      st       = 0;
      if (!was_busy) begin
        st = tk || force_send || m_pend;
      end else if (slots[0].kind == K_LOAD) begin
        slots.delete(0);
        for (int c = 0; c < NCH; c++) push_frame(c, t_data[16*c +: 16], m_alarm[c], m_forced);
      end else if (slots[0].kind == K_BYTE) begin
        if (tx_rdy) slots.delete(0);
      end else begin
        if (slots[0].last && m_pend) st = 1;
        slots.delete(0);
      end
      if (st) begin
        m_forced = force_send || m_pforce;
        m_pend = 0; m_pforce = 0;
        s.kind = K_LOAD; s.d = 8'h00; s.last = 0;
        slots.push_back(s);
      end else if (was_busy) begin
        if (tk || force_send) m_pend = 1;
        if (force_send) m_pforce = 1;
      end
      for (int k = 0; k < NCH; k++) begin
        int tv;
        tv = int'($signed(t_data[16*k +: 16]));
        if (tv >= 480) m_alarm[k] = 1;
        else if (tv < 480 - 32) m_alarm[k] = 0;
      end
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = (slots.size() > 0) && (slots[0].kind == K_BYTE);
      check("tx_vld", 32'(tx_vld), 32'(ev));
      if (ev) check("tx_data", 32'(tx_data), 32'(slots[0].d));
      check("busy", 32'(busy), 32'(slots.size() > 0));
      check("alarm", 32'(alarm), {30'b0, m_alarm[1], m_alarm[0]});
      check("alarm_any", 32'(alarm_any), 32'(m_alarm[0] | m_alarm[1]));
      if (busy) busy_cnt++;
    end
  end

  logic [7:0] cap[$];
  always @(posedge clk) if (rst_n && tx_vld && tx_rdy) cap.push_back(tx_data);

  // ---------------- stimulus helpers ----------------
  task automatic pulse_force();
    force_send = 1'b1;
    @(negedge clk);
    force_send = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 60 && cap.size() < n; i++) @(negedge clk);
    check("cap_timeout", 32'(cap.size()), 32'(n));
  endtask

  task automatic wait_safe();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && m_cnt >= 16 && m_cnt <= 50 && !m_pend) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("safe_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 16'($urandom);
      1:       pick = 16'h01DF;
      2:       pick = 16'h01E0;
      3:       pick = 16'h01C0;
      4:       pick = 16'h01BF;
      default: pick = 16'h0191;
    endcase
  endfunction

  localparam logic [7:0] EXP_F [12] = '{8'hA5, 8'h00, 8'h01, 8'h91, 8'h02, 8'h39,
                                        8'hA5, 8'h01, 8'hFF, 8'h5E, 8'h02, 8'h05};
  localparam logic [7:0] EXP_P [12] = '{8'hA5, 8'h00, 8'h01, 8'h91, 8'h00, 8'h37,
                                        8'hA5, 8'h01, 8'hFF, 8'h5E, 8'h00, 8'h03};
  localparam logic [15:0] SWEEP_T [5] = '{16'h01DF, 16'h01E0, 16'h01C0, 16'h01BF, 16'hFF00};
  localparam logic        SWEEP_A [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_n      = 1'b0;
    force_send = 1'b0;
    tx_rdy     = 1'b1;
    t_data     = {16'hFF5E, 16'h0191};
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_vld", 32'(tx_vld), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_alarm_any", 32'(alarm_any), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Forced two-channel report.
    cap.delete();
    busy_cnt = 0;
    pulse_force();
    wait_idle();
    check("forced_busy_len", 32'(busy_cnt), 32'd15);
    check("forced_len", 32'(cap.size()), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("forced_b%0d", i), 32'(cap[i]), 32'(EXP_F[i]));
    check("forced_alarm", 32'(alarm), 32'd0);

    // Next report comes from the period tick.
    cap.delete();
    for (int i = 0; i < 200 && !busy; i++) @(negedge clk);
    wait_idle();
    check("period_len", 32'(cap.size()), 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("period_b%0d", i), 32'(cap[i]), 32'(EXP_P[i]));

    // Alarm hysteresis sweep on channel 0.
    for (int i = 0; i < 5; i++) begin
      t_data[15:0] = SWEEP_T[i];
      repeat (2) @(negedge clk);
      check($sformatf("sweep%0d", i), 32'(alarm[0]), 32'(SWEEP_A[i]));
    end
    t_data[15:0] = 16'h0191;
    repeat (2) @(negedge clk);

    // Snapshot held while the live reading changes mid-frame.
    wait_safe();
    cap.delete();
    pulse_force();
    wait_cap(2);
    t_data[15:0] = 16'h0200;
    wait_idle();
    check("snap_hi", 32'(cap[2]), 32'h01);
    check("snap_lo", 32'(cap[3]), 32'h91);
    wait_safe();
    cap.delete();
    pulse_force();
    wait_idle();
    check("snap2_hi", 32'(cap[2]), 32'h02);
    check("snap2_lo", 32'(cap[3]), 32'h00);
    check("snap2_flags", 32'(cap[4]), 32'h03);

    // Reset in the middle of byte 3.
    wait_safe();
    cap.delete();
    pulse_force();
    wait_cap(3);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx_vld", 32'(tx_vld), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_alarm", 32'(alarm), 32'd0);
    repeat (2) @(negedge clk);
    t_data[15:0] = 16'h0191;
    #1 rst_n = 1'b1;
    cap.delete();
    repeat (3) @(negedge clk);
    check("postrst_idle", 32'(busy), 32'd0);
    check("postrst_nocap", 32'(cap.size()), 32'd0);
    pulse_force();
    wait_idle();
    check("postrst_len", 32'(cap.size()), 32'd12);
    check("postrst_sof", 32'(cap[0]), 32'hA5);

    // Tick and force_send in the same cycle: a single forced report.
    for (int i = 0; i < 300 && !(m_cnt == PCYC - 1 && !busy); i++) @(negedge clk);
    cap.delete();
    busy_cnt = 0;
    pulse_force();
    wait_idle();
    check("tickforce_busy_len", 32'(busy_cnt), 32'd15);
    check("tickforce_len", 32'(cap.size()), 32'd12);
    check("tickforce_flags0", 32'(cap[4]), 32'h02);
    check("tickforce_flags1", 32'(cap[10]), 32'h02);

    // Two triggers during one report: exactly one follow-up, no idle gap.
    wait_safe();
    cap.delete();
    busy_cnt = 0;
    pulse_force();
    repeat (2) @(negedge clk);
    pulse_force();
    @(negedge clk);
    pulse_force();
    wait_idle();
    check("b2b_busy_len", 32'(busy_cnt), 32'd30);
    check("b2b_len", 32'(cap.size()), 32'd24);
    check("b2b_sof2", 32'(cap[12]), 32'hA5);
    check("b2b_flags2", 32'(cap[16]), 32'h02);

    // Randomized traffic with back-pressure against the model.
    for (int i = 0; i < 3000; i++) begin
      tx_rdy     = ($urandom_range(0, 9) < 6);
      force_send = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) t_data[15:0]  = pick();
      if ($urandom_range(0, 19) == 0) t_data[31:16] = pick();
      @(negedge clk);
    end
    force_send = 1'b0;
    tx_rdy     = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
